// File: rtl/divisor.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Optional early overflow/divide-by-zero exit is enabled by defining DIVISOR_OVF_CHECK_EN.
module divisor #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           done,
  input  logic [2*N-1:0] P_in,
  input  logic [N-1:0]   B_in,
  output logic [N-1:0]   Q_out,
  output logic [N-1:0]   R_out,
  output logic           ovf
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned RW = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OVF  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [RW-1:0]   r;
  logic [N-1:0]    q;
  logic [N-1:0]    bq;
  logic [CW-1:0]   cnt;

  logic [RW-1:0]   r_shift_c;
  logic [RW-1:0]   r_next_c;
  logic [N-1:0]    q_next_c;
  logic            fits_c;
  logic            ovf_hit_c;

  // One restoring step: shift {r,q} left, subtract the divisor if it fits.
  always_comb begin
    r_shift_c = RW'({r, q[N-1]});
    fits_c    = (r_shift_c >= {1'b0, bq});
    r_next_c  = fits_c ? (r_shift_c - {1'b0, bq}) : r_shift_c;
    q_next_c  = N'({q, fits_c});
  end

`ifdef DIVISOR_OVF_CHECK_EN
  // Quotient cannot fit in N bits when the high dividend half is not below the divisor.
  assign ovf_hit_c = (P_in[2*N-1:N] >= B_in);
`else
  assign ovf_hit_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      r     <= '0;
      q     <= '0;
      bq    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      Q_out <= '0;
      R_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bq    <= B_in;
            r     <= {1'b0, P_in[2*N-1:N]};
            q     <= P_in[N-1:0];
            cnt   <= CW'(N);
            done  <= 1'b0;
            ovf   <= 1'b0;
            state <= ovf_hit_c ? OVF : CALC;
          end
        end
        CALC: begin
          r   <= r_next_c;
          q   <= q_next_c;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            Q_out <= q_next_c;
            R_out <= r_next_c[N-1:0];
          end
        end
        OVF: begin
          state <= DONE;
          done  <= 1'b1;
          ovf   <= 1'b1;
          Q_out <= '1;
          R_out <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor (N=4): directed cases plus random divisions against
// plain integer division; overflow cases run only when DIVISOR_OVF_CHECK_EN is defined.
module tb_divisor;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           done;
  logic [2*N-1:0] P_in;
  logic [N-1:0]   B_in;
  logic [N-1:0]   Q_out;
  logic [N-1:0]   R_out;
  logic           ovf;

  int n_checks = 0;
  int n_fails  = 0;
  int prev_q   = 0;
  int prev_r   = 0;

  divisor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .done  (done),
    .P_in  (P_in),
    .B_in  (B_in),
    .Q_out (Q_out),
    .R_out (R_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns just after the accepting edge.
  task automatic start_op(input int p, input int b);
    @(negedge clk);
    start = 1'b1;
    P_in  = (2*N)'(p);
    B_in  = N'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_low_after_accept", int'(done), 0);
  endtask

  // Expect done to rise exactly N edges after acceptance with the model's result.
  task automatic expect_result(input string tag, input int p, input int b);
    int eq, er;
    eq = p / b;
    er = p % b;
    for (int i = 1; i < int'(N); i++) begin
      @(posedge clk);
      #1;
      check({tag, "_done_calc"}, int'(done), 0);
      check({tag, "_q_held"}, int'(Q_out), prev_q);
    end
    @(posedge clk);
    #1;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_q"}, int'(Q_out), eq);
    check({tag, "_r"}, int'(R_out), er);
    check({tag, "_ovf"}, int'(ovf), 0);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic run_div(input string tag, input int p, input int b);
    start_op(p, b);
    expect_result(tag, p, b);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b, p;
    rst   = 1'b0;
    start = 1'b0;
    P_in  = '0;
    B_in  = '0;
    #1;
    check("reset_done", int'(done), 0);
    check("reset_ovf", int'(ovf), 0);
    check("reset_q", int'(Q_out), 0);
    check("reset_r", int'(R_out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_div("basic", 100, 7);
    run_div("max", 239, 15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", int'(done), 1);
      check("hold_q", int'(Q_out), 15);
      check("hold_r", int'(R_out), 14);
    end
    run_div("zero_dividend", 0, 5);

`ifdef DIVISOR_OVF_CHECK_EN
    start_op(200, 3);
    @(posedge clk);
    #1;
    check("ovf_done", int'(done), 1);
    check("ovf_flag", int'(ovf), 1);
    check("ovf_q", int'(Q_out), 15);
    check("ovf_r", int'(R_out), 0);
    start_op(9, 0);
    @(posedge clk);
    #1;
    check("dbz_done", int'(done), 1);
    check("dbz_flag", int'(ovf), 1);
    check("dbz_q", int'(Q_out), 15);
    check("dbz_r", int'(R_out), 0);
    prev_q = 15;
    prev_r = 0;
`endif

    // A second start two cycles into CALC must not disturb the running division.
    start_op(100, 7);
    @(posedge clk);
    #1;
    check("ign_done1", int'(done), 0);
    start = 1'b1;
    P_in  = 8'd50;
    B_in  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_done2", int'(done), 0);
    @(posedge clk);
    #1;
    check("ign_done3", int'(done), 0);
    @(posedge clk);
    #1;
    check("ign_done", int'(done), 1);
    check("ign_q", int'(Q_out), 14);
    check("ign_r", int'(R_out), 2);
    prev_q = 14;
    prev_r = 2;

    run_div("b2b", 119, 8);

    for (int i = 0; i < 25; i++) begin
      b = int'($urandom_range(1, 15));
      p = int'($urandom_range(0, 16 * b - 1));
      run_div("rand", p, b);
    end

    // Asynchronous reset in the middle of CALC clears outputs without a clock edge.
    start_op(100, 7);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_done", int'(done), 0);
    check("arst_ovf", int'(ovf), 0);
    check("arst_q", int'(Q_out), 0);
    check("arst_r", int'(R_out), 0);
    prev_q = 0;
    prev_r = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_div("after_reset", 100, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/divisor.md
# divisor

Sequential restoring divider, the inverse of the team's shift-add multiplier: it takes a 2N-bit dividend and an N-bit divisor and produces an N-bit quotient and N-bit remainder.
- Shares the start/done handshake of the multiplier.
- Multiplier products can be fed straight back to recover an operand.
- Computes one quotient bit per clock over N cycles.
- Flags divide-by-zero and quotient overflow.

## Interface
Parameters:
- N, default 4: operand width; dividend is 2N bits; quotient and remainder are N bits each.

Ports:
- clk  input  1  clock; rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge.
- done  output  1  result valid (level).
- P_in  input  2N  dividend; captured when start is accepted.
- B_in  input  N  divisor; captured when start is accepted.
- Q_out  output  N  quotient.
- R_out  output  N  remainder.
- ovf  output  1  overflow/divide-by-zero flag; valid with done.

## Operation
- States:
  - IDLE: no operation in progress.
  - CALC: iterating, cycle counter from N down to 1.
  - DONE: result held.
- Internal registers:
  - R: (N+1)-bit partial remainder.
  - Q: N-bit shift register.
  - Bq: N-bit captured divisor.
  - cnt: counter, at least clog2(N+1) bits.
- Start acceptance: start=1 on an edge in IDLE or DONE.
  - Bq <= B_in; R <= {1'b0, P_in[2N-1:N]}; Q <= P_in[N-1:0].
  - done <= 0; ovf <= 0; cnt <= N.
  - Next state is CALC, unless the overflow check (Configuration) sends it to DONE.
- CALC, each edge:
  - {R,Q} shifts left one bit.
  - If shifted R >= {0,Bq}: R <= shifted R - Bq and Q[0] <= 1; otherwise Q[0] <= 0.
  - cnt decrements. On the edge where cnt reaches 0: state <= DONE, done <= 1, Q_out <= Q, R_out <= R[N-1:0].
- DONE: outputs held stable until the next accepted start. start=0 keeps the block in DONE indefinitely. There is no return to IDLE other than reset.
- start while in CALC is ignored; no restart and no effect on the result.
- Precondition for correct results: P_in[2N-1:N] < B_in. Under it, R never exceeds N+1 bits and Q_out*B_in + R_out == P_in with R_out < B_in.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state = IDLE, done = 0, ovf = 0.
  - Q_out = 0, R_out = 0, all internal registers 0.
- Release of rst is synchronous to clk. Reset mid-CALC aborts the operation; no partial result appears.
- Normal latency:
  - start accepted on edge k; done rises after edge k+N.
  - Q_out, R_out and ovf change only on the same edge as done rises.
- Overflow latency (macro enabled): done and ovf rise after edge k+1.
- A back-to-back start accepted while in DONE drops done after that edge. The new result appears with normal latency.
- Q_out and R_out keep the previous result during CALC. Only done qualifies them.

## Configuration
- DIVISOR_OVF_CHECK_EN defined:
  - At start acceptance, if P_in[2N-1:N] >= B_in (this includes B_in == 0), the block skips CALC.
  - Next edge: state DONE, done = 1, ovf = 1, Q_out = all ones, R_out = 0.
- Not defined:
  - ovf is tied to 0 and CALC always runs N cycles.
  - Q_out/R_out are unspecified for inputs that violate the precondition; the bench must not check them.

## Test plan (N=4)
- Basic division: reset low for 2 cycles, release; P_in=100, B_in=7, one-cycle start.
  - Required: done rises exactly 4 edges after acceptance; Q_out=14, R_out=2, ovf=0.
- Boundary values: P_in=239, B_in=15 gives Q_out=15, R_out=14. P_in=0, B_in=5 gives Q_out=0, R_out=0. Results hold while start=0 for 10 cycles.
- Overflow and divide-by-zero (macro defined):
  - P_in=200, B_in=3: done and ovf high after 1 edge; Q_out=4'hF, R_out=0.
  - P_in=9, B_in=0: same response.
- start ignored in CALC: accept P_in=100, B_in=7, then pulse start with P_in=50, B_in=3 two cycles later.
  - Required: result still 14 r 2 at edge k+4.
- Back-to-back: from DONE, accept P_in=119, B_in=8.
  - Required: done drops after the accepting edge, then rises 4 edges later with Q_out=14, R_out=7.
- Reset mid-operation: assert rst=0 asynchronously during CALC.
  - Required: done, ovf, Q_out and R_out go to 0 immediately, without waiting for a clock edge.
  - After release, a new division (P_in=100, B_in=7) completes correctly with normal latency.
